// File: rtl/debug_id_dump_pkg.sv
// Shared definitions for the ID/EX debug dump: frame geometry, byte offsets,
// FSM states and the index-width helper.
package debug_id_dump_pkg;

    localparam int         FRAME_BYTES = 20;
    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam int         CTRL_BITS   = 13;

    localparam int OFF_A      = 1;
    localparam int OFF_B      = 5;
    localparam int OFF_EXT    = 9;
    localparam int OFF_REGS   = 13;
    localparam int OFF_CTRL   = 15;
    localparam int OFF_BRANCH = 17;
    localparam int OFF_CHK    = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

    // Number of bits needed to hold the given value.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dump_byte_mux.sv
// Selects one frame byte from the frozen snapshot by byte index.
// The checksum slot is left at zero; the top supplies it from its own register.
module dump_byte_mux
    import debug_id_dump_pkg::*;
#(
    parameter int CANT_BITS_REGISTROS = 32,
    parameter int CANT_BITS_ADDR      = 11,
    parameter int REG_W               = 5
) (
    input  logic [CANT_BITS_REGISTROS-1:0] data_a,
    input  logic [CANT_BITS_REGISTROS-1:0] data_b,
    input  logic [CANT_BITS_REGISTROS-1:0] ext_const,
    input  logic [REG_W-1:0]               reg_rs,
    input  logic [REG_W-1:0]               reg_rt,
    input  logic [REG_W-1:0]               reg_rd,
    input  logic [CTRL_BITS-1:0]           ctrl,
    input  logic [CANT_BITS_ADDR-1:0]      branch_dir,
    input  logic                           branch_control,
    input  logic [4:0]                     byte_index,
    output logic [7:0]                     frame_byte
);

    logic [31:0] word_a;
    logic [31:0] word_b;
    logic [31:0] word_ext;
    logic [15:0] word_regs;
    logic [15:0] word_ctrl;
    logic [15:0] word_branch;
    int          idx;

    assign word_a      = 32'(data_a);
    assign word_b      = 32'(data_b);
    assign word_ext    = 32'(ext_const);
    assign word_regs   = 16'({reg_rs, reg_rt, reg_rd});
    assign word_ctrl   = 16'(ctrl);
    assign word_branch = 16'({branch_control, branch_dir});
    assign idx         = 32'(byte_index);

    function automatic logic [7:0] pick32(input logic [31:0] w, input int k);
        return w[8*(3-k) +: 8];
    endfunction

    function automatic logic [7:0] pick16(input logic [15:0] w, input int k);
        return w[8*(1-k) +: 8];
    endfunction

    always_comb begin
        frame_byte = '0;
        if (idx < OFF_A)
            frame_byte = HEADER_BYTE;
        else if (idx < OFF_B)
            frame_byte = pick32(word_a, idx - OFF_A);
        else if (idx < OFF_EXT)
            frame_byte = pick32(word_b, idx - OFF_B);
        else if (idx < OFF_REGS)
            frame_byte = pick32(word_ext, idx - OFF_EXT);
        else if (idx < OFF_CTRL)
            frame_byte = pick16(word_regs, idx - OFF_REGS);
        else if (idx < OFF_BRANCH)
            frame_byte = pick16(word_ctrl, idx - OFF_CTRL);
        else if (idx < OFF_CHK)
            frame_byte = pick16(word_branch, idx - OFF_BRANCH);
    end

endmodule

// File: rtl/debug_id_dump.sv
// Snapshots the ID/EX latch on request and streams it as a 20-byte framed,
// XOR-checksummed packet over a valid/ready byte handshake.
module debug_id_dump
    import debug_id_dump_pkg::*;
#(
    parameter int CANT_BITS_REGISTROS   = 32,
    parameter int CANT_BITS_ADDR        = 11,
    parameter int CANT_REGISTROS        = 32,
    parameter int CANT_BITS_ALU_OP      = 2,
    parameter int CANT_BITS_ALU_CONTROL = 4
) (
    input  logic                                         i_clock,
    input  logic                                         i_soft_reset,
    input  logic                                         i_start,
    input  logic [CANT_BITS_REGISTROS-1:0]               i_data_A,
    input  logic [CANT_BITS_REGISTROS-1:0]               i_data_B,
    input  logic [CANT_BITS_REGISTROS-1:0]               i_extension_signo_constante,
    input  logic [clogb2(CANT_REGISTROS-1)-1:0]          i_reg_rs,
    input  logic [clogb2(CANT_REGISTROS-1)-1:0]          i_reg_rt,
    input  logic [clogb2(CANT_REGISTROS-1)-1:0]          i_reg_rd,
    input  logic [CANT_BITS_ALU_OP+CANT_BITS_ALU_CONTROL+7-1:0] i_ctrl,
    input  logic [CANT_BITS_ADDR-1:0]                    i_branch_dir,
    input  logic                                         i_branch_control,
    input  logic                                         i_tx_ready,
    output logic [7:0]                                   o_tx_data,
    output logic                                         o_tx_valid,
    output logic                                         o_busy,
    output logic                                         o_done
);

    localparam int         REG_W    = clogb2(CANT_REGISTROS - 1);
    localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);
    localparam logic [4:0] CHK_IDX  = 5'(OFF_CHK);

    dump_state_t                    state;
    logic [4:0]                     byte_idx;
    logic [7:0]                     checksum;
    logic [7:0]                     mux_byte;

    logic [CANT_BITS_REGISTROS-1:0] snap_a;
    logic [CANT_BITS_REGISTROS-1:0] snap_b;
    logic [CANT_BITS_REGISTROS-1:0] snap_ext;
    logic [REG_W-1:0]               snap_rs;
    logic [REG_W-1:0]               snap_rt;
    logic [REG_W-1:0]               snap_rd;
    logic [CTRL_BITS-1:0]           snap_ctrl;
    logic [CANT_BITS_ADDR-1:0]      snap_bdir;
    logic                           snap_bctl;

    dump_byte_mux #(
        .CANT_BITS_REGISTROS (CANT_BITS_REGISTROS),
        .CANT_BITS_ADDR      (CANT_BITS_ADDR),
        .REG_W               (REG_W)
    ) u_byte_mux (
        .data_a         (snap_a),
        .data_b         (snap_b),
        .ext_const      (snap_ext),
        .reg_rs         (snap_rs),
        .reg_rt         (snap_rt),
        .reg_rd         (snap_rd),
        .ctrl           (snap_ctrl),
        .branch_dir     (snap_bdir),
        .branch_control (snap_bctl),
        .byte_index     (byte_idx),
        .frame_byte     (mux_byte)
    );

    // Only registered state feeds the bus, so the byte holds while ready is low.
    always_comb begin
        o_tx_data = '0;
        if (state == ST_SEND)
            o_tx_data = (byte_idx == CHK_IDX) ? checksum : mux_byte;
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state      <= ST_IDLE;
            byte_idx   <= '0;
            checksum   <= '0;
            snap_a     <= '0;
            snap_b     <= '0;
            snap_ext   <= '0;
            snap_rs    <= '0;
            snap_rt    <= '0;
            snap_rd    <= '0;
            snap_ctrl  <= '0;
            snap_bdir  <= '0;
            snap_bctl  <= 1'b0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        snap_a     <= i_data_A;
                        snap_b     <= i_data_B;
                        snap_ext   <= i_extension_signo_constante;
                        snap_rs    <= i_reg_rs;
                        snap_rt    <= i_reg_rt;
                        snap_rd    <= i_reg_rd;
                        snap_ctrl  <= CTRL_BITS'(i_ctrl);
                        snap_bdir  <= i_branch_dir;
                        snap_bctl  <= i_branch_control;
                        byte_idx   <= '0;
                        checksum   <= '0;
                        o_tx_valid <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        checksum <= checksum ^ o_tx_data;
                        if (byte_idx == LAST_IDX) begin
                            o_tx_valid <= 1'b0;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            byte_idx <= byte_idx + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    o_done   <= 1'b0;
                    byte_idx <= '0;
                    state    <= ST_IDLE;
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    o_done     <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
